// File: rtl/tape_pkg.sv
// Shared definitions for the Oric .TAP player: frame constants, FSM state type
// and the bit-cell timing helper.
package tape_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        PARITY_ODD = 1'b1;
    localparam int unsigned BAUD_X2    = 4800;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_ACK,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_LAST,
        ST_DONE
    } tap_state_t;

    // Short half-cell length in clock cycles; the long low phase is twice this.
    function automatic int unsigned short_cell(input int unsigned clk_hz);
        return clk_hz / BAUD_X2;
    endfunction

endpackage

// File: rtl/tape_bit_gen.sv
// One Oric fast-format bit cell: high for T_S, then low for T_S ('1') or T_L ('0').
// bit_done marks the last cycle of a cell so the next cell can start without a gap.
module tape_bit_gen
    import tape_pkg::*;
#(
    parameter int unsigned CLK_HZ = 24000000
) (
    input  logic clk_sys,
    input  logic res_n,
    input  logic abort,
    input  logic bit_go,
    input  logic bit_in,
    output logic tape_out,
    output logic bit_done,
    output logic cell_busy
);

    localparam int unsigned T_S = short_cell(CLK_HZ);
    localparam int unsigned T_L = 2 * T_S;
    localparam int unsigned CW  = $clog2(T_L + 1);

    logic          active;
    logic          high_phase;
    logic          cur_bit;
    logic [CW-1:0] cnt;

    assign bit_done  = active && !high_phase && (cnt == '0);
    assign cell_busy = active;

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            active     <= 1'b0;
            high_phase <= 1'b0;
            cur_bit    <= 1'b0;
            cnt        <= '0;
            tape_out   <= 1'b0;
        end else if (abort) begin
            active     <= 1'b0;
            high_phase <= 1'b0;
            cnt        <= '0;
            tape_out   <= 1'b0;
        end else if (bit_go && (!active || bit_done)) begin
            active     <= 1'b1;
            high_phase <= 1'b1;
            cur_bit    <= bit_in;
            cnt        <= CW'(T_S - 1);
            tape_out   <= 1'b1;
        end else if (active) begin
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else if (high_phase) begin
                high_phase <= 1'b0;
                tape_out   <= 1'b0;
                cnt        <= cur_bit ? CW'(T_S - 1) : CW'(T_L - 1);
            end else begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tap_player.sv
// Oric .TAP cassette transmitter: fetches image bytes, frames them and drives tape_out.
// Optional TAP_REMOTE_EN: the motor relay gates playback at byte boundaries.
module tap_player
    import tape_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 24000000,
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned STOP_BITS = 4
) (
    input  logic              clk_sys,
    input  logic              res_n,
    input  logic              play,
    input  logic              rewind,
    input  logic [ADDR_W-1:0] img_len,
    input  logic              remote,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [7:0]        rd_data,
    output logic              tape_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned SCW = $clog2(STOP_BITS + 1);

    tap_state_t     state;
    logic [7:0]     buf_data;
    logic           buf_valid;
    logic           discard;
    logic [7:0]     cur_byte;
    logic [2:0]     bit_idx;
    logic [SCW-1:0] stop_cnt;
    logic           frame_ok;
    logic           bit_go;
    logic           bit_val;
    logic           bit_done;
    logic           cell_busy;
    logic           gen_free;
    logic           more_bytes;
    logic           prefetch_ok;

`ifdef TAP_REMOTE_EN
    assign frame_ok = play && remote;
`else
    logic remote_unused;
    assign remote_unused = remote;
    assign frame_ok      = play;
`endif

    assign gen_free    = !cell_busy || bit_done;
    assign more_bytes  = buf_valid || (rd_addr < img_len);
    assign prefetch_ok = frame_ok && (rd_addr < img_len) &&
                         (state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP});
    assign busy        = !(state inside {ST_IDLE, ST_DONE});

    // A bit is launched into the generator only when the previous cell is on its
    // last cycle (or idle), which keeps cells back-to-back and makes pausing bit-exact.
    always_comb begin
        bit_go  = 1'b0;
        bit_val = 1'b0;
        if (gen_free && !rewind) begin
            case (state)
                ST_START:  if (buf_valid && frame_ok) bit_go = 1'b1;
                ST_DATA:   begin bit_go = play; bit_val = cur_byte[bit_idx]; end
                ST_PARITY: begin bit_go = play; bit_val = (^cur_byte) ^ PARITY_ODD; end
                ST_STOP:   begin bit_go = play; bit_val = 1'b1; end
                default:   bit_go = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            state     <= ST_IDLE;
            rd_req    <= 1'b0;
            rd_addr   <= '0;
            buf_data  <= '0;
            buf_valid <= 1'b0;
            discard   <= 1'b0;
            cur_byte  <= '0;
            bit_idx   <= '0;
            stop_cnt  <= '0;
            done      <= 1'b0;
        end else if (rewind) begin
            state     <= ST_IDLE;
            rd_addr   <= '0;
            done      <= 1'b0;
            buf_valid <= 1'b0;
            // An outstanding read cannot be withdrawn; its data is dropped on arrival.
            if (rd_req && !rd_ack) begin
                discard <= 1'b1;
            end else begin
                rd_req  <= 1'b0;
                discard <= 1'b0;
            end
        end else begin
            if (rd_req && rd_ack) begin
                rd_req  <= 1'b0;
                discard <= 1'b0;
                if (!discard) begin
                    buf_data  <= rd_data;
                    buf_valid <= 1'b1;
                    rd_addr   <= rd_addr + 1'b1;
                end
            end else if (!rd_req && !buf_valid && prefetch_ok) begin
                rd_req <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (frame_ok && !rd_req && !done && (rd_addr < img_len))
                        state <= ST_FETCH;
                end
                ST_FETCH: begin
                    rd_req <= 1'b1;
                    state  <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (buf_valid) state <= ST_START;
                end
                ST_START: begin
                    if (bit_go) begin
                        cur_byte  <= buf_data;
                        buf_valid <= 1'b0;
                        bit_idx   <= '0;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_go) begin
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'(DATA_BITS - 1)) state <= ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if (bit_go) begin
                        stop_cnt <= '0;
                        state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_go) begin
                        if (stop_cnt == SCW'(STOP_BITS - 1))
                            state <= more_bytes ? ST_START : ST_LAST;
                        else
                            stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                ST_LAST: begin
                    if (bit_done) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    tape_bit_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_bit_gen (
        .clk_sys  (clk_sys),
        .res_n    (res_n),
        .abort    (rewind),
        .bit_go   (bit_go),
        .bit_in   (bit_val),
        .tape_out (tape_out),
        .bit_done (bit_done),
        .cell_busy(cell_busy)
    );

endmodule
